// File: rtl/master.sv
// master: Wishbone B.4 pipelined master issuing one read then one write per request
`ifndef IPL_READ_ADDR
`define IPL_READ_ADDR 16'h1000
`endif
`ifndef IPL_WRITE_ADDR
`define IPL_WRITE_ADDR 16'h2000
`endif

module master #(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] READ_ADDR  = ADDR_WIDTH'(`IPL_READ_ADDR),
    parameter logic [ADDR_WIDTH-1:0] WRITE_ADDR = ADDR_WIDTH'(`IPL_WRITE_ADDR)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  dreq_i,
    output logic                  dack_o,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  we_o,
    input  logic                  ack_i
);
    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT} state_t;

    state_t                state_q, state_d;
    logic                  cyc_q, cyc_d, stb_q, stb_d, we_q, we_d, dack_q, dack_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;

    // next state: a write ack re-samples dreq_i to chain straight into the next read
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = dreq_i ? RD_ISSUE : IDLE;
            RD_ISSUE: state_d = ack_i ? WR_ISSUE : RD_WAIT;
            RD_WAIT:  state_d = ack_i ? WR_ISSUE : RD_WAIT;
            WR_ISSUE: state_d = ack_i ? (dreq_i ? RD_ISSUE : IDLE) : WR_WAIT;
            WR_WAIT:  state_d = ack_i ? (dreq_i ? RD_ISSUE : IDLE) : WR_WAIT;
            default:  state_d = IDLE;
        endcase
    end

    // output decode of the upcoming state so the registered outputs track state_q
    always_comb begin
        cyc_d  = state_d != IDLE;
        stb_d  = state_d == RD_ISSUE || state_d == WR_ISSUE;
        we_d   = state_d == WR_ISSUE;
        dack_d = state_d == RD_ISSUE;
        adr_d  = state_d == RD_ISSUE ? READ_ADDR : state_d == WR_ISSUE ? WRITE_ADDR : '0;
    end

    // state and output registers, cleared immediately on reset
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            dack_q  <= 1'b0;
            adr_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            dack_q  <= dack_d;
            adr_q   <= adr_d;
        end
    end

    assign cyc_o  = cyc_q;
    assign stb_o  = stb_q;
    assign we_o   = we_q;
    assign dack_o = dack_q;
    assign adr_o  = adr_q;
endmodule

// File: tb/tb_master.sv
// tb_master: vector table plus scoreboard check of the read/write bus master
module tb_master;
    localparam logic [15:0] RA = 16'h1234;
    localparam logic [15:0] WA = 16'hABCD;
    localparam logic [19:0] O_ID = 20'h0;
    localparam logic [19:0] O_RI = {4'b1101, RA};
    localparam logic [19:0] O_WT = {4'b1000, 16'h0};
    localparam logic [19:0] O_WI = {4'b1110, WA};

    typedef struct {
        logic        dreq;
        logic        ack;
        logic [19:0] exp;
        string       name;
    } vec_t;

    logic        clk = 0, rst = 1, dreq = 0, ack = 0;
    logic        dack, cyc, stb, we;
    logic [15:0] adr;
    logic [19:0] sb_q[$];
    int          n_chk = 0, n_fail = 0;
    vec_t        vt[20];

    master #(.ADDR_WIDTH(16), .READ_ADDR(RA), .WRITE_ADDR(WA)) dut (
        .clk_i(clk), .reset_i(rst), .dreq_i(dreq), .dack_o(dack), .adr_o(adr),
        .cyc_o(cyc), .stb_o(stb), .we_o(we), .ack_i(ack)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] outs();
        return {cyc, stb, we, dack, adr};
    endfunction

    task automatic check(input string name, input logic [19:0] exp);
        logic [19:0] act;
        act = outs();
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got cyc/stb/we/dack/adr=%h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input string name, input logic d, input logic a, input logic [19:0] exp);
        logic [19:0] e;
        sb_q.push_back(exp);
        dreq = d;
        ack  = a;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            check(name, e);
        end
    endtask

    initial begin
        vt[0]  = '{1'b0, 1'b0, O_ID, "idle"};
        vt[1]  = '{1'b1, 1'b0, O_RI, "read_strobe"};
        vt[2]  = '{1'b0, 1'b0, O_WT, "read_wait"};
        vt[3]  = '{1'b0, 1'b1, O_WI, "write_strobe"};
        vt[4]  = '{1'b0, 1'b0, O_WT, "write_wait"};
        vt[5]  = '{1'b0, 1'b1, O_ID, "write_ack_idle"};
        vt[6]  = '{1'b0, 1'b1, O_ID, "ack_ignored_idle"};
        vt[7]  = '{1'b1, 1'b1, O_RI, "b2b_rd0"};
        vt[8]  = '{1'b1, 1'b1, O_WI, "b2b_wr0"};
        vt[9]  = '{1'b1, 1'b1, O_RI, "b2b_rd1"};
        vt[10] = '{1'b1, 1'b1, O_WI, "b2b_wr1"};
        vt[11] = '{1'b0, 1'b1, O_ID, "drop_dreq_on_write"};
        vt[12] = '{1'b1, 1'b0, O_RI, "read_strobe2"};
        vt[13] = '{1'b1, 1'b0, O_WT, "dreq_ignored_rdwait"};
        vt[14] = '{1'b0, 1'b1, O_WI, "write_strobe2"};
        vt[15] = '{1'b1, 1'b0, O_WT, "write_wait2"};
        vt[16] = '{1'b1, 1'b1, O_RI, "pending_dreq_serviced"};
        vt[17] = '{1'b0, 1'b0, O_WT, "read_wait3"};
        vt[18] = '{1'b0, 1'b1, O_WI, "write_strobe3"};
        vt[19] = '{1'b0, 1'b0, O_WT, "write_wait3"};
        #2;
        check("reset_outputs", O_ID);
        @(posedge clk);
        #1;
        rst = 0;
        for (int i = 0; i < 20; i++) step(vt[i].name, vt[i].dreq, vt[i].ack, vt[i].exp);
        #3;
        rst = 1;
        #1;
        check("async_reset_wr_wait", O_ID);
        #1;
        rst = 0;
        step("post_reset_idle0", 1'b0, 1'b1, O_ID);
        step("post_reset_idle1", 1'b0, 1'b0, O_ID);
        step("post_reset_dreq", 1'b1, 1'b1, O_RI);
        step("post_reset_zero_wait_wr", 1'b0, 1'b1, O_WI);
        step("post_reset_done", 1'b0, 1'b1, O_ID);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
